// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word fetches under credit-based flow control,
// buffers in-order memory responses and squashes in-flight fetches on a redirect.
module ifetch_queue #(
    parameter int unsigned WORD    = 32,
    parameter int unsigned ADDR    = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned RST_PC  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   req_o,
    output logic [ADDR-1:0]        req_addr_o,
    input  logic                   gnt_i,
    input  logic                   rvalid_i,
    input  logic [WORD-1:0]        rdata_i,
    input  logic                   branch_i,
    input  logic [ADDR-1:0]        baddr_i,
    output logic                   v_o,
    output logic [WORD-1:0]        inst_o,
    output logic [ADDR-1:0]        pc_o,
    input  logic                   ready_i,
    output logic [$clog2(DEPTH):0] occ_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    logic [ADDR-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic [PW:0]     occ_q, occ_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;

    logic [WORD-1:0] inst_q [DEPTH];
    logic [ADDR-1:0] pc_q   [DEPTH];

    logic        accept, rsp, push, pop;
    logic [31:0] live_inflight;

    // Requests whose data will still land in the queue count against its free space.
    assign live_inflight = 32'(outst_q) - 32'(drop_q);
    assign req_o      = !rst && (32'(outst_q) < MAX_OUT)
                        && ((live_inflight + 32'(occ_q)) < DEPTH);
    assign req_addr_o = fetch_pc_q;

    assign accept = req_o && gnt_i;
    assign rsp    = rvalid_i && (outst_q != '0);
    assign push   = rsp && !branch_i && (drop_q == '0);
    assign pop    = v_o && ready_i && !branch_i;

    assign v_o    = (occ_q != '0);
    assign occ_o  = occ_q;
    assign inst_o = inst_q[rptr_q];
    assign pc_o   = pc_q[rptr_q];

    always_comb begin
        outst_d    = outst_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        occ_d      = occ_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;

        if (accept) begin
            outst_d    = outst_d + OW'(1);
            fetch_pc_d = fetch_pc_q + ADDR'(1);
        end
        if (rsp) begin
            outst_d = outst_d - OW'(1);
        end

        if (branch_i) begin
            // Everything still in flight after this edge belongs to the old path.
            drop_d     = outst_d;
            fetch_pc_d = baddr_i;
            resp_pc_d  = baddr_i;
            occ_d      = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end else begin
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + ADDR'(1);
                wptr_d    = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            occ_d = occ_q + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= ADDR'(RST_PC);
            resp_pc_q  <= ADDR'(RST_PC);
            outst_q    <= '0;
            drop_q     <= '0;
            occ_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wptr_q] <= rdata_i;
            pc_q[wptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: default instance plus a 4-bit-address instance for wrap.
module tb_ifetch_queue;
    localparam int unsigned WORD = 32;
    localparam int unsigned ADDR = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_o, gnt_i, rvalid_i, branch_i, v_o, ready_i;
    logic [ADDR-1:0] req_addr_o, baddr_i, pc_o;
    logic [WORD-1:0] rdata_i, inst_o;
    logic [2:0]      occ_o;

    logic            req4_o, rvalid4_i, v4_o;
    logic [3:0]      req_addr4_o, pc4_o;
    logic [WORD-1:0] rdata4_i, inst4_o;
    logic [2:0]      occ4_o;

    int n_tests = 0;
    int n_fail  = 0;
    int accepts = 0;
    bit auto_rsp = 1'b0;
    logic [ADDR-1:0] pending [$];
    logic            acc4;
    logic [3:0]      acc4_addr;

    always #5 clk = ~clk;

    ifetch_queue u_dut (
        .clk(clk), .rst(rst), .req_o(req_o), .req_addr_o(req_addr_o), .gnt_i(gnt_i),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .branch_i(branch_i), .baddr_i(baddr_i),
        .v_o(v_o), .inst_o(inst_o), .pc_o(pc_o), .ready_i(ready_i), .occ_o(occ_o)
    );

    ifetch_queue #(.ADDR(4), .RST_PC(14)) u_dut4 (
        .clk(clk), .rst(rst), .req_o(req4_o), .req_addr_o(req_addr4_o), .gnt_i(1'b1),
        .rvalid_i(rvalid4_i), .rdata_i(rdata4_i), .branch_i(1'b0), .baddr_i(4'h0),
        .v_o(v4_o), .inst_o(inst4_o), .pc_o(pc4_o), .ready_i(1'b1), .occ_o(occ4_o)
    );

    function automatic logic [WORD-1:0] memval(input logic [ADDR-1:0] a);
        return {16'hC0DE, a};
    endfunction

    function automatic logic [WORD-1:0] mem4(input logic [3:0] a);
        return {28'hBEEF000, a};
    endfunction

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic clk_cycle();
        #1;
        if (req_o && gnt_i) begin
            pending.push_back(req_addr_o);
            accepts++;
        end
        acc4      = req4_o;
        acc4_addr = req_addr4_o;
        @(negedge clk);
        rvalid4_i = acc4;
        rdata4_i  = mem4(acc4_addr);
        rvalid_i  = 1'b0;
        if (auto_rsp && pending.size() > 0) begin
            rvalid_i = 1'b1;
            rdata_i  = memval(pending.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; auto_rsp = 1'b0; rvalid_i = 1'b0; rvalid4_i = 1'b0;
        gnt_i = 1'b0; ready_i = 1'b0; branch_i = 1'b0; baddr_i = '0;
        pending.delete();
        accepts = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; gnt_i = 1'b1; ready_i = 1'b0; branch_i = 1'b0; baddr_i = '0;
        rvalid_i = 1'b0; rdata_i = '0; rvalid4_i = 1'b0; rdata4_i = '0;
        @(negedge clk); #1;
        n_tests++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", req_o); end
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL rst_v: got %b want 0", v_o); end
        n_tests++; if (occ_o !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", occ_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL rel_req: got %b want 1", req_o); end
        n_tests++; if (req_addr_o !== 16'h0) begin n_fail++; $display("FAIL rel_addr: got %0h want 0", req_addr_o); end
        n_tests++; if (req_addr4_o !== 4'hE) begin n_fail++; $display("FAIL rel_addr4: got %0h want e", req_addr4_o); end
    endtask

    task automatic test_stream();
        logic [ADDR-1:0] exp_pc;
        exp_pc = '0;
        gnt_i = 1'b1; ready_i = 1'b1; auto_rsp = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            clk_cycle();
            if (i >= 2) begin
                n_tests++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL stream_v cyc %0d: got %b want 1", i, v_o); end
            end
            if (v_o === 1'b1) begin
                n_tests++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL stream_pc: got %0h want %0h", pc_o, exp_pc); end
                n_tests++; if (inst_o !== memval(exp_pc)) begin n_fail++; $display("FAIL stream_inst: got %0h want %0h", inst_o, memval(exp_pc)); end
                exp_pc = exp_pc + 16'd1;
            end
        end
        n_tests++; if (exp_pc !== 16'd11) begin n_fail++; $display("FAIL stream_count: got %0d want 11", exp_pc); end
    endtask

    task automatic test_backpressure();
        do_reset();
        gnt_i = 1'b1; ready_i = 1'b0; auto_rsp = 1'b1;
        repeat (8) clk_cycle();
        n_tests++; if (occ_o !== 3'd4) begin n_fail++; $display("FAIL bp_full_occ: got %0d want 4", occ_o); end
        n_tests++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b want 0", req_o); end
        n_tests++; if (accepts != 4) begin n_fail++; $display("FAIL bp_full_acc: got %0d want 4", accepts); end
        n_tests++; if (pc_o !== 16'h0) begin n_fail++; $display("FAIL bp_head: got %0h want 0", pc_o); end
        ready_i = 1'b1;
        clk_cycle();
        ready_i = 1'b0;
        n_tests++; if (occ_o !== 3'd3) begin n_fail++; $display("FAIL bp_pop_occ: got %0d want 3", occ_o); end
        n_tests++; if (pc_o !== 16'h1) begin n_fail++; $display("FAIL bp_pop_pc: got %0h want 1", pc_o); end
        n_tests++; if (req_o !== 1'b1 || req_addr_o !== 16'h4) begin n_fail++; $display("FAIL bp_req: got %b/%0h want 1/4", req_o, req_addr_o); end
        repeat (4) clk_cycle();
        n_tests++; if (occ_o !== 3'd4) begin n_fail++; $display("FAIL bp_refill_occ: got %0d want 4", occ_o); end
        n_tests++; if (accepts != 5) begin n_fail++; $display("FAIL bp_refill_acc: got %0d want 5", accepts); end
        n_tests++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL bp_refill_req: got %b want 0", req_o); end
    endtask

    task automatic test_branch_drop();
        do_reset();
        ready_i = 1'b1; branch_i = 1'b1; baddr_i = 16'h5;
        clk_cycle();
        branch_i = 1'b0; gnt_i = 1'b1;
        n_tests++; if (req_addr_o !== 16'h5) begin n_fail++; $display("FAIL bd_addr5: got %0h want 5", req_addr_o); end
        clk_cycle();
        clk_cycle();
        gnt_i = 1'b0;
        n_tests++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL bd_maxout: got %b want 0", req_o); end
        branch_i = 1'b1; baddr_i = 16'h40;
        clk_cycle();
        branch_i = 1'b0;
        n_tests++; if (req_addr_o !== 16'h40) begin n_fail++; $display("FAIL bd_target: got %0h want 40", req_addr_o); end
        rvalid_i = 1'b1; rdata_i = memval(16'h5);
        clk_cycle();
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL bd_drop5: got v %b want 0", v_o); end
        rvalid_i = 1'b1; rdata_i = memval(16'h6);
        clk_cycle();
        n_tests++; if (v_o !== 1'b0 || occ_o !== 3'd0) begin n_fail++; $display("FAIL bd_drop6: got v %b occ %0d want 0/0", v_o, occ_o); end
        n_tests++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL bd_req: got %b want 1", req_o); end
        gnt_i = 1'b1;
        clk_cycle();
        gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = memval(16'h40);
        clk_cycle();
        n_tests++; if (v_o !== 1'b1 || pc_o !== 16'h40) begin n_fail++; $display("FAIL bd_new: got v %b pc %0h want 1/40", v_o, pc_o); end
        n_tests++; if (inst_o !== memval(16'h40)) begin n_fail++; $display("FAIL bd_inst: got %0h want %0h", inst_o, memval(16'h40)); end
    endtask

    task automatic test_branch_coincident();
        do_reset();
        ready_i = 1'b1; gnt_i = 1'b1;
        clk_cycle();
        rvalid_i = 1'b1; rdata_i = memval(16'h0); branch_i = 1'b1; baddr_i = 16'h20;
        n_tests++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL bc_req: got %b want 1", req_o); end
        clk_cycle();
        branch_i = 1'b0; gnt_i = 1'b0;
        n_tests++; if (v_o !== 1'b0 || occ_o !== 3'd0) begin n_fail++; $display("FAIL bc_flush: got v %b occ %0d want 0/0", v_o, occ_o); end
        n_tests++; if (req_addr_o !== 16'h20) begin n_fail++; $display("FAIL bc_target: got %0h want 20", req_addr_o); end
        rvalid_i = 1'b1; rdata_i = memval(16'h1);
        clk_cycle();
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL bc_stale: got v %b want 0", v_o); end
        gnt_i = 1'b1;
        clk_cycle();
        gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = memval(16'h20);
        clk_cycle();
        n_tests++; if (v_o !== 1'b1 || pc_o !== 16'h20) begin n_fail++; $display("FAIL bc_new: got v %b pc %0h want 1/20", v_o, pc_o); end
        n_tests++; if (inst_o !== memval(16'h20)) begin n_fail++; $display("FAIL bc_inst: got %0h want %0h", inst_o, memval(16'h20)); end
    endtask

    task automatic test_back_to_back();
        branch_i = 1'b1; baddr_i = 16'h30;
        clk_cycle();
        baddr_i = 16'h50;
        clk_cycle();
        branch_i = 1'b0;
        n_tests++; if (v_o !== 1'b0 || occ_o !== 3'd0) begin n_fail++; $display("FAIL b2b_flush: got v %b occ %0d want 0/0", v_o, occ_o); end
        n_tests++; if (req_addr_o !== 16'h50) begin n_fail++; $display("FAIL b2b_target: got %0h want 50", req_addr_o); end
        gnt_i = 1'b1;
        clk_cycle();
        gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = memval(16'h50);
        clk_cycle();
        n_tests++; if (v_o !== 1'b1 || pc_o !== 16'h50) begin n_fail++; $display("FAIL b2b_new: got v %b pc %0h want 1/50", v_o, pc_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        gnt_i = 1'b1; ready_i = 1'b0; auto_rsp = 1'b1;
        for (int i = 0; i < 20 && occ_o !== 3'd3; i++) clk_cycle();
        n_tests++; if (occ_o !== 3'd3) begin n_fail++; $display("FAIL rm_fill: got %0d want 3", occ_o); end
        rst = 1'b1; auto_rsp = 1'b0; rvalid_i = 1'b0; pending.delete();
        #1;
        n_tests++; if (v_o !== 1'b0 || req_o !== 1'b0) begin n_fail++; $display("FAIL rm_async: got v %b req %b want 0/0", v_o, req_o); end
        n_tests++; if (occ_o !== 3'd0) begin n_fail++; $display("FAIL rm_occ: got %0d want 0", occ_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (req_o !== 1'b1 || req_addr_o !== 16'h0) begin n_fail++; $display("FAIL rm_release: got %b/%0h want 1/0", req_o, req_addr_o); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp4 [4];
        int got;
        exp4 = '{4'hE, 4'hF, 4'h0, 4'h1};
        got = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            clk_cycle();
            if (v4_o === 1'b1 && got < 4) begin
                n_tests++; if (pc4_o !== exp4[got]) begin n_fail++; $display("FAIL wrap_pc %0d: got %0h want %0h", got, pc4_o, exp4[got]); end
                n_tests++; if (inst4_o !== mem4(exp4[got])) begin n_fail++; $display("FAIL wrap_inst %0d: got %0h want %0h", got, inst4_o, mem4(exp4[got])); end
                got++;
            end
        end
        n_tests++; if (got != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", got); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_drop();
        test_branch_coincident();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter WORD, default 32, instruction width in bits.
REQ-002 Parameter ADDR, default 16, word-address width in bits.
REQ-003 Parameter DEPTH, default 4, instruction-queue entries; power of 2, at least 2.
REQ-004 Parameter MAX_OUT, default 2, maximum memory requests in flight; range 1..DEPTH.
REQ-005 Parameter RST_PC, default 0, fetch address after reset.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 req_o  out  1  memory read request valid.
REQ-009 req_addr_o  out  ADDR  word address of the request.
REQ-010 gnt_i  in  1  memory accepts the request this cycle.
REQ-011 rvalid_i  in  1  read data valid; responses return in request order, latency at least 1 cycle.
REQ-012 rdata_i  in  WORD  read data.
REQ-013 branch_i  in  1  redirect fetch this cycle.
REQ-014 baddr_i  in  ADDR  redirect target address.
REQ-015 v_o  out  1  queue head valid.
REQ-016 inst_o  out  WORD  head instruction.
REQ-017 pc_o  out  ADDR  head instruction address.
REQ-018 ready_i  in  1  consumer takes the head this cycle.
REQ-019 occ_o  out  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-020 The block SHALL track fetch_pc, resp_pc, outstanding (0..MAX_OUT), drop_cnt (0..outstanding) and occ (0..DEPTH).
REQ-021 req_o SHALL be combinational: (outstanding < MAX_OUT) and ((outstanding - drop_cnt) + occ < DEPTH) and not rst; req_addr_o = fetch_pc.
REQ-022 A request is accepted on req_o & gnt_i; acceptance SHALL increment fetch_pc by 1, modulo 2^ADDR (wrap to 0 permitted).
REQ-023 outstanding_next = outstanding + accept - rvalid_i; rvalid_i with outstanding = 0 is a protocol violation, SHALL be ignored, and SHALL NOT change any state.
REQ-024 A response with drop_cnt > 0 SHALL be discarded and decrement drop_cnt by 1.
REQ-025 A response with drop_cnt = 0 SHALL push {rdata_i, resp_pc} at the tail and increment resp_pc modulo 2^ADDR.
REQ-026 v_o = (occ != 0); inst_o and pc_o SHALL come from the head entry, with no combinational path from rdata_i (minimum 1 cycle from rvalid_i to v_o).
REQ-027 v_o & ready_i SHALL pop the head; simultaneous push and pop SHALL leave occ unchanged; read and write pointers wrap modulo DEPTH.
REQ-028 Push when full cannot occur because of REQ-021 credit; the credit rule SHALL guarantee this.
REQ-029 branch_i at a posedge SHALL take priority over all other events: queue emptied (occ = 0), pops and pushes that cycle ignored, fetch_pc and resp_pc loaded with baddr_i, drop_cnt loaded with outstanding_next, including a request accepted in the same cycle.
REQ-030 A response arriving in the branch cycle SHALL be discarded and counted in outstanding_next.
REQ-031 A request accepted in the cycle after branch_i SHALL use req_addr_o = baddr_i.
REQ-032 Back-to-back branch_i cycles SHALL each apply REQ-029; the last target wins.
REQ-033 Without branch_i, instructions SHALL leave the queue in fetch order with contiguous pc_o values.

Reset
REQ-034 While rst is high: req_o = 0, v_o = 0, occ_o = 0, outstanding = 0, drop_cnt = 0, fetch_pc = resp_pc = RST_PC, pointers = 0.
REQ-035 Reset asserted mid-operation SHALL discard all queue contents and in-flight tracking immediately; responses arriving after reset for pre-reset requests are a system violation.
REQ-036 In the first cycle after deassertion, req_o SHALL be 1 with req_addr_o = RST_PC.

Verification
REQ-037 Single-cycle memory, gnt_i = 1, ready_i = 1 after reset -> pc_o sequence 0,1,2,3..., inst_o matches memory, steady throughput of 1 per cycle once MAX_OUT >= 2.
REQ-038 ready_i = 0 with DEPTH = 4 -> occ_o reaches 4, req_o falls to 0 with no further accepts; one ready_i pulse -> exactly one pop and one new request.
REQ-039 Two requests in flight (addresses 5, 6), branch_i with baddr_i = 0x40 -> drop_cnt = 2, both responses discarded, next v_o shows pc_o = 0x40.
REQ-040 branch_i coincident with an accept and a response -> drop_cnt = outstanding + 1 - 1, no stale pc_o ever reaches v_o.
REQ-041 ADDR = 4, fetch from 0xE -> pc_o 0xE, 0xF, 0x0, 0x1.
REQ-042 rst pulsed with queue at occ 3 -> v_o = 0 and req_o = 0 at once; after release req_addr_o = RST_PC.
